// File: rtl/dmem_arb_pkg.sv
// Shared encodings and helpers for the data-memory arbiter: access-size codes,
// byte-lane enables and the alignment check.
package dmem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Load response captured at grant time, consumed one cycle later.
  typedef struct packed {
    logic       valid;
    logic       port;
    logic       err;
    logic [1:0] off;
    logic [1:0] size;
    logic       sext;
  } resp_t;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << off;
      SZ_HALF: sel = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a memory word, moves it to bit 0 and
// sign- or zero-extends it; full words pass straight through.
module dmem_load_align
  import dmem_arb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{sext & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory (port 0 CPU,
// port 1 debug/DMA). Define DMEM_ARB_RR_EN for round-robin, else port 0 wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [1:0]        size_0,
  input  logic              sext_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              err_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [1:0]        size_1,
  input  logic              sext_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              err_1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              any_req;
  logic              win;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [1:0]        g_size;
  logic              g_sext;
  logic [DATA_W-1:0] g_wdata;
  logic              g_err;
  logic [DATA_W-1:0] rep_wdata;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  resp_t             resp_q, resp_d;
  logic [31:0]       aligned;
  logic [1:0]        rv_v;
  logic [1:0]        er_v;
  logic [DATA_W-1:0] rd_v [2];

  assign any_req = req_0 | req_1;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer names the favoured port and flips away from whoever was just granted.
  always_comb begin
    win   = (req_0 & req_1) ? ptr_q : req_1;
    ptr_d = ptr_q;
    if (any_req) ptr_d = ~win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = ~req_0;
  end
`endif

  assign gnt_0 = any_req & ~win;
  assign gnt_1 = any_req & win;

  always_comb begin
    g_we    = win ? we_1    : we_0;
    g_addr  = win ? addr_1  : addr_0;
    g_size  = win ? size_1  : size_0;
    g_sext  = win ? sext_1  : sext_0;
    g_wdata = win ? wdata_1 : wdata_0;
    g_err   = misaligned(g_size, g_addr[1:0]);
  end

  always_comb begin
    case (g_size)
      SZ_BYTE: rep_wdata = {4{g_wdata[7:0]}};
      SZ_HALF: rep_wdata = {2{g_wdata[15:0]}};
      default: rep_wdata = g_wdata;
    endcase
  end

  // Faulting accesses are granted but never reach the memory write port.
  always_comb begin
    mem_we        = any_req & g_we & ~g_err;
    mem_wdata_sel = mem_we ? lane_sel(g_size, g_addr[1:0]) : 4'b0000;
    mem_wdata     = mem_we ? rep_wdata : '0;
    mem_addr      = any_req ? g_addr : last_addr_q;
    last_addr_d   = mem_addr;
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = any_req & (~g_we | g_err);
    resp_d.port  = win;
    resp_d.err   = g_err;
    resp_d.off   = g_addr[1:0];
    resp_d.size  = g_size;
    resp_d.sext  = g_sext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr_q <= '0;
      resp_q      <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      resp_q      <= resp_d;
    end
  end

  dmem_load_align u_align (
    .rdata (mem_rdata),
    .off   (resp_q.off),
    .size  (resp_q.size),
    .sext  (resp_q.sext),
    .data  (aligned)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rv_v[gi] = resp_q.valid & (resp_q.port == 1'(gi));
      assign er_v[gi] = rv_v[gi] & resp_q.err;
      assign rd_v[gi] = (rv_v[gi] & ~resp_q.err) ? aligned : '0;
    end
  endgenerate

  assign rvalid_0 = rv_v[0];
  assign err_0    = er_v[0];
  assign rdata_0  = rd_v[0];
  assign rvalid_1 = rv_v[1];
  assign err_1    = er_v[1];
  assign rdata_1  = rd_v[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases then random traffic, checked against a
// byte-array memory model with a simple grant model (RR with DMEM_ARB_RR_EN).
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        r_req [2];
  logic        r_we [2];
  logic        r_sext [2];
  logic [1:0]  r_size [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];

  logic        gnt_0, rvalid_0, err_0, gnt_1, rvalid_1, err_1;
  logic [31:0] rdata_0, rdata_1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wdata_sel;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_0(r_req[0]), .we_0(r_we[0]), .addr_0(r_addr[0]), .size_0(r_size[0]),
    .sext_0(r_sext[0]), .wdata_0(r_wdata[0]), .gnt_0(gnt_0), .rvalid_0(rvalid_0),
    .rdata_0(rdata_0), .err_0(err_0),
    .req_1(r_req[1]), .we_1(r_we[1]), .addr_1(r_addr[1]), .size_1(r_size[1]),
    .sext_1(r_sext[1]), .wdata_1(r_wdata[1]), .gnt_1(gnt_1), .rvalid_1(rvalid_1),
    .rdata_1(rdata_1), .err_1(err_1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata_sel(mem_wdata_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // The data memory itself: 256 words, lane-writable, registered read.
  logic [31:0] ram [256];
  logic        fill_en = 1'b0;
  logic [7:0]  fill_idx = 8'd0;
  logic [31:0] fill_word = 32'd0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return m;
  endfunction

  always @(posedge clk) begin
    if (fill_en) ram[fill_idx] <= fill_word;
    else if (mem_we) ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wdata, mem_wdata_sel);
    mem_rdata <= mem_we ? merge(ram[mem_addr[9:2]], mem_wdata, mem_wdata_sel)
                        : ram[mem_addr[9:2]];
  end

  // Reference model state.
  logic [7:0]  ref_mem [1024];
  int          last_gnt;
  logic [31:0] last_addr_m;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [1:0]  obs_gnt;
  logic        obs_we;
  logic [3:0]  obs_sel;
  logic        obs_rv [2];
  logic        obs_err [2];
  logic [31:0] obs_rd [2];
  bit          model_any;
  int          model_g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input int p, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit sext, input logic [31:0] wdata);
    r_req[p] = 1'b1; r_we[p] = we; r_addr[p] = addr;
    r_size[p] = size; r_sext[p] = sext; r_wdata[p] = wdata;
  endtask

  task automatic idle();
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
  endtask

  task automatic new_req(input int p);
    int sz;
    logic [31:0] a;
    sz = $urandom_range(0, 9);
    sz = (sz < 3) ? 0 : (sz < 6) ? 1 : (sz < 9) ? 2 : 3;
    a = 32'($urandom_range(0, 63));
    if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
    a = a | (32'($urandom_range(0, 7)) << 12);
    drive(p, 1'($urandom_range(0, 1)), a, 2'(sz), 1'($urandom_range(0, 1)), $urandom);
    r_req[p] = ($urandom_range(0, 9) < 6);
  endtask

  // One clock cycle: inputs are already driven (just after a rising edge).
  task automatic step();
    bit          any, e, st;
    int          g, n, off, idx;
    logic [31:0] a, v, exp_wd;
    logic [3:0]  exp_sel;
    logic        erv [2];
    logic        eerr [2];
    logic [31:0] erd [2];
    #1;
    cyc++;
    any = r_req[0] || r_req[1];
    if (r_req[0] && r_req[1]) g = RR ? (1 - last_gnt) : 0;
    else g = r_req[1] ? 1 : 0;
    a   = r_addr[g];
    n   = 1 << r_size[g];
    off = int'(a[1:0]);
    idx = int'(a[9:0]);
    e   = (r_size[g] == 2'b11) || (a % n != 0);
    st  = any && r_we[g] && !e;
    exp_sel = 4'b0000;
    exp_wd  = 32'd0;
    if (st) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= off && k < off + n) exp_sel[k] = 1'b1;
        exp_wd[8*k +: 8] = r_wdata[g][8*(k % n) +: 8];
      end
    end
    check_eq("gnt_0", gnt_0, 32'(any && g == 0));
    check_eq("gnt_1", gnt_1, 32'(any && g == 1));
    check_eq("mem_we", mem_we, 32'(st));
    check_eq("mem_sel", mem_wdata_sel, exp_sel);
    if (st) check_eq("mem_wdata", mem_wdata, exp_wd);
    check_eq("mem_addr", mem_addr, any ? a : last_addr_m);
    obs_gnt = {gnt_1, gnt_0};
    obs_we  = mem_we;
    obs_sel = mem_wdata_sel;

    for (int p = 0; p < 2; p++) begin
      erv[p] = 1'b0; eerr[p] = 1'b0; erd[p] = 32'd0;
    end
    if (any && (e || !r_we[g])) begin
      erv[g]  = 1'b1;
      eerr[g] = e;
      if (!e) begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[idx + k];
        if (r_sext[g] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        erd[g] = v;
      end
    end
    if (st) for (int k = 0; k < n; k++) ref_mem[idx + k] = r_wdata[g][8*k +: 8];
    model_any = any;
    model_g   = g;
    if (any) begin
      $display("txn cyc=%0d port=%0d %s addr=%h size=%0d sext=%0d wdata=%h err=%0d",
               cyc, g, r_we[g] ? "st" : "ld", a, r_size[g], r_sext[g], r_wdata[g], e);
      last_gnt    = g;
      last_addr_m = a;
    end

    @(posedge clk);
    #1;
    check_eq("rvalid_0", rvalid_0, 32'(erv[0]));
    check_eq("err_0", err_0, 32'(eerr[0]));
    check_eq("rdata_0", rdata_0, erd[0]);
    check_eq("rvalid_1", rvalid_1, 32'(erv[1]));
    check_eq("err_1", err_1, 32'(eerr[1]));
    check_eq("rdata_1", rdata_1, erd[1]);
    obs_rv[0] = rvalid_0; obs_err[0] = err_0; obs_rd[0] = rdata_0;
    obs_rv[1] = rvalid_1; obs_err[1] = err_1; obs_rd[1] = rdata_1;
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_rvalid_0"}, rvalid_0, 32'd0);
    check_eq({pfx, "_rvalid_1"}, rvalid_1, 32'd0);
    check_eq({pfx, "_err_0"}, err_0, 32'd0);
    check_eq({pfx, "_err_1"}, err_1, 32'd0);
    check_eq({pfx, "_rdata_0"}, rdata_0, 32'd0);
    check_eq({pfx, "_rdata_1"}, rdata_1, 32'd0);
    check_eq({pfx, "_mem_we"}, mem_we, 32'd0);
    check_eq({pfx, "_mem_sel"}, mem_wdata_sel, 32'd0);
    check_eq({pfx, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_sext[p] = 1'b0;
      r_size[p] = 2'b00; r_addr[p] = 32'd0; r_wdata[p] = 32'd0;
    end
    last_gnt    = 1;
    last_addr_m = 32'd0;

    // Preload memory and model while reset holds the arbiter.
    @(negedge clk);
    fill_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      fill_idx  = 8'(i);
      fill_word = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = fill_word[8*k +: 8];
      @(negedge clk);
    end
    fill_en = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // Both ports contend every cycle.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b0, 32'h40 + 32'(4*i), 2'b10, 1'b0, 32'd0);
      drive(1, 1'b0, 32'h80 + 32'(4*i), 2'b10, 1'b0, 32'd0);
      step();
      check_eq("rr_gnt0", 32'(obs_gnt[0]), RR ? 32'(i % 2 == 0) : 32'd1);
      check_eq("rr_gnt1", 32'(obs_gnt[1]), RR ? 32'(i % 2 == 1) : 32'd0);
    end

    idle(); drive(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344); step();
    check_eq("st_word_sel", obs_sel, 32'hF);
    idle(); drive(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0); step();
    check_eq("ld_word_rv", obs_rv[0], 32'd1);
    check_eq("ld_word_data", obs_rd[0], 32'h1122_3344);

    idle(); drive(0, 1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_00AB); step();
    check_eq("st_byte_sel", obs_sel, 32'h8);
    idle(); drive(0, 1'b0, 32'h13, 2'b00, 1'b1, 32'd0); step();
    check_eq("ld_byte_sext", obs_rd[0], 32'hFFFF_FFAB);
    idle(); drive(0, 1'b0, 32'h13, 2'b00, 1'b0, 32'd0); step();
    check_eq("ld_byte_zext", obs_rd[0], 32'h0000_00AB);

    idle(); drive(1, 1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_8001); step();
    check_eq("st_half_sel", obs_sel, 32'hC);
    idle(); drive(1, 1'b0, 32'h22, 2'b01, 1'b1, 32'd0); step();
    check_eq("ld_half_sext", obs_rd[1], 32'hFFFF_8001);

    idle(); drive(0, 1'b0, 32'h06, 2'b10, 1'b0, 32'd0); step();
    check_eq("mis_gnt", 32'(obs_gnt[0]), 32'd1);
    check_eq("mis_we", obs_we, 32'd0);
    check_eq("mis_rv", obs_rv[0], 32'd1);
    check_eq("mis_err", obs_err[0], 32'd1);
    check_eq("mis_rdata", obs_rd[0], 32'd0);
    idle(); drive(0, 1'b1, 32'h05, 2'b01, 1'b0, 32'hDEAD_BEEF); step();
    check_eq("mis_st_err", obs_err[0], 32'd1);
    idle(); drive(0, 1'b0, 32'h04, 2'b10, 1'b0, 32'd0); step();

    // Reset lands in the middle of a load's grant cycle.
    idle(); drive(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
    #1;
    check_eq("rst_gnt0", gnt_0, 32'd1);
    #2;
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check_quiet("mid_reset");
    last_gnt    = 1;
    last_addr_m = 32'd0;
    reset = 1'b0;

    new_req(0);
    new_req(1);
    for (int i = 0; i < 300; i++) begin
      step();
      for (int p = 0; p < 2; p++)
        if (!r_req[p] || (model_any && model_g == p)) new_req(p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
